// File: rtl/ula_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode constants,
// FSM state encoding and the operand width.
package ula_arbiter_pkg;

  localparam int W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NOT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ula_arbiter_if.sv
// Bundle of requester handshakes, the external ALU hookup and the response
// channel; slave is the arbiter side, master the environment side.
interface ula_arbiter_if;
  import ula_arbiter_pkg::*;

  logic         req0_valid;
  logic         req1_valid;
  logic         req0_ready;
  logic         req1_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [2:0]   req0_op;
  logic [2:0]   req1_op;
  logic [W-1:0] ula_a;
  logic [W-1:0] ula_b;
  logic         ula_x;
  logic         ula_y;
  logic         ula_z;
  logic [W-1:0] ula_s;
  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_ready;
  logic         busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, ula_s, rsp_ready,
    output req0_ready, req1_ready, ula_a, ula_b, ula_x, ula_y, ula_z,
           rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, ula_s, rsp_ready,
    input  req0_ready, req1_ready, ula_a, ula_b, ula_x, ula_y, ula_z,
           rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/ula_rr_arb.sv
// Two-way arbiter: combinational one-hot grant while enabled, with a
// last-grant pointer that only moves when a grant is actually issued.
module ula_rr_arb #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic       r_last;
  logic [1:0] w_grant;

  // Under contention the requester not served last wins; fixed mode favours 0.
  always_comb begin
    w_grant = 2'b00;
    if (i_en) begin
      if (&i_req) w_grant = (RR && !r_last) ? 2'b10 : 2'b01;
      else        w_grant = i_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             r_last <= 1'b1;
    else if (|w_grant)   r_last <= w_grant[1];
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/ula_arbiter.sv
// Shares one external combinational ALU between two requesters using a
// three-state IDLE/EXEC/RESP sequencer with latched operands.
module ula_arbiter
  import ula_arbiter_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  ula_arbiter_if.slave  bus
);

  state_e       r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  op_e          r_op;
  logic         r_id;
  logic [W-1:0] r_data;
  logic         r_rsp_valid;
  logic         r_busy;
  logic         w_idle;
  logic [1:0]   w_grant;

  // Reset gates the enable so no ready can leak out during a reset cycle.
  assign w_idle = (r_state == ST_IDLE) && !rst;

  ula_rr_arb #(.RR(RR)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_idle),
    .i_req   ({bus.req1_valid, bus.req0_valid}),
    .o_grant (w_grant)
  );

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_ADD;
      r_id        <= 1'b0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_a     <= w_grant[1] ? bus.req1_a : bus.req0_a;
            r_b     <= w_grant[1] ? bus.req1_b : bus.req0_b;
            r_op    <= op_e'(w_grant[1] ? bus.req1_op : bus.req0_op);
            r_id    <= w_grant[1];
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_data      <= bus.ula_s;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // ALU inputs always come from the latched copy, so they only move on acceptance.
  assign bus.ula_a = r_a;
  assign bus.ula_b = r_b;
  assign {bus.ula_z, bus.ula_y, bus.ula_x} = r_op;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_data;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_ula_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed grants/results, monitors
// compare them against what the arbiters present.
module tb_ula_arbiter;
  import ula_arbiter_pkg::*;

  typedef struct packed { logic id; logic [3:0] data; } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  rsp_t exp_rsp[$];
  logic exp_gnt[$];
  rsp_t exp_rsp_fp[$];
  logic exp_gnt_fp[$];

  ula_arbiter_if bus ();
  ula_arbiter_if bus0 ();

  ula_arbiter #(.RR(1'b1)) dut    (.clk(clk), .rst(rst), .bus(bus));
  ula_arbiter #(.RR(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU model.
  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [3:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a << b;
      3'd3: r = a >> b;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  assign bus.ula_s  = alu(bus.ula_a, bus.ula_b, {bus.ula_z, bus.ula_y, bus.ula_x});
  assign bus0.ula_s = alu(bus0.ula_a, bus0.ula_b, {bus0.ula_z, bus0.ula_y, bus0.ula_x});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no matching event, required one (cycle %0d)", name, cyc);
  endtask

  // Monitor for the round-robin instance.
  logic       g;
  rsp_t       e;
  int         acc_cyc;
  logic [2:0] acc_op;
  logic [3:0] acc_a, acc_b;
  logic       prev_valid, prev_taken, prev_id;
  logic [3:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.req0_ready || bus.req1_ready) begin
        if (exp_gnt.size() == 0) fail("unexpected_ready");
        else begin
          g = exp_gnt.pop_front();
          check("grant", {bus.req1_ready, bus.req0_ready}, g ? 2'b10 : 2'b01);
          acc_cyc <= cyc;
          acc_op  <= bus.req1_ready ? bus.req1_op : bus.req0_op;
          acc_a   <= bus.req1_ready ? bus.req1_a  : bus.req0_a;
          acc_b   <= bus.req1_ready ? bus.req1_b  : bus.req0_b;
        end
      end
      if (bus.busy && !bus.rsp_valid) begin
        check("exec_zyx", {bus.ula_z, bus.ula_y, bus.ula_x}, acc_op);
        check("exec_ab", {bus.ula_a, bus.ula_b}, {acc_a, acc_b});
      end
      if (bus.rsp_valid) begin
        if (!prev_valid) check("latency", cyc - acc_cyc, 2);
        else if (!prev_taken) check("bp_stable", {bus.rsp_id, bus.rsp_data}, {prev_id, prev_data});
        if (bus.rsp_ready) begin
          if (exp_rsp.size() == 0) fail("unexpected_rsp");
          else begin
            e = exp_rsp.pop_front();
            check("rsp_id", bus.rsp_id, e.id);
            check("rsp_data", bus.rsp_data, e.data);
          end
        end
      end
      prev_valid <= bus.rsp_valid;
      prev_taken <= bus.rsp_ready;
      prev_id    <= bus.rsp_id;
      prev_data  <= bus.rsp_data;
    end
  end

  // Monitor for the fixed-priority instance.
  logic g_fp;
  rsp_t e_fp;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.req0_ready || bus0.req1_ready) begin
        if (exp_gnt_fp.size() == 0) fail("fp_unexpected_ready");
        else begin
          g_fp = exp_gnt_fp.pop_front();
          check("fp_grant", {bus0.req1_ready, bus0.req0_ready}, g_fp ? 2'b10 : 2'b01);
        end
      end
      if (bus0.rsp_valid && bus0.rsp_ready) begin
        if (exp_rsp_fp.size() == 0) fail("fp_unexpected_rsp");
        else begin
          e_fp = exp_rsp_fp.pop_front();
          check("fp_rsp_id", bus0.rsp_id, e_fp.id);
          check("fp_rsp_data", bus0.rsp_data, e_fp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic who, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    if (!who) begin bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; end
    else      begin bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; end
  endtask

  // Raise the masked valids, hold until any ready, drop right after the accept edge.
  task automatic issue(input logic [1:0] mask);
    bit got = 1'b0;
    bus.req0_valid = mask[0];
    bus.req1_valid = mask[1];
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin got = 1'b1; break; end
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (!got) fail("issue_timeout");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    tick();
    if (!ok) fail("idle_timeout");
  endtask

  logic [3:0] op_res [8] = '{4'd7, 4'd3, 4'd4, 4'd1, 4'd0, 4'd7, 4'd7, 4'd10};

  initial begin
    int n, c0, cl, n0;
    bit got, done1;
    rst = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1'b1;
    bus0.req0_valid = 0; bus0.req1_valid = 0; bus0.rsp_ready = 1'b1;
    set_req(0, 4'd0, 4'd0, 3'd0);
    set_req(1, 4'd0, 4'd0, 3'd0);
    bus0.req0_a = 0; bus0.req0_b = 0; bus0.req0_op = 0;
    bus0.req1_a = 0; bus0.req1_b = 0; bus0.req1_op = 0;
    tick(); tick();

    // Valids during reset must not produce ready or change the pointer.
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ula_ab", {bus.ula_a, bus.ula_b}, 8'h00);
    check("rst_ula_zyx", {bus.ula_z, bus.ula_y, bus.ula_x}, 3'd0);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", bus.busy, 1'b0);
    tick();

    // Single add with wrap: 9+8 = 1.
    exp_gnt.push_back(1'b0); exp_rsp.push_back('{1'b0, 4'd1});
    set_req(0, 4'd9, 4'd8, 3'd0);
    issue(2'b01);
    wait_idle();

    // All opcodes, a=5 b=2, alternating requesters.
    for (int op = 0; op < 8; op++) begin
      exp_gnt.push_back(op[0]);
      exp_rsp.push_back('{op[0], op_res[op]});
      set_req(op[0], 4'd5, 4'd2, op[2:0]);
      issue(op[0] ? 2'b10 : 2'b01);
      wait_idle();
    end

    // Round-robin contention: last grant was 1, so 0,1,0,1.
    set_req(0, 4'd1, 4'd1, 3'd0);
    set_req(1, 4'd3, 4'd5, 3'd6);
    for (int i = 0; i < 2; i++) begin
      exp_gnt.push_back(1'b0); exp_rsp.push_back('{1'b0, 4'd2});
      exp_gnt.push_back(1'b1); exp_rsp.push_back('{1'b1, 4'd6});
    end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    n = 0; c0 = 0; cl = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        if (n == 0) c0 = cyc;
        n++;
        cl = cyc;
      end
      tick();
      if (n == 4) break;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("rr_accepts", n, 4);
    check("rr_span", cl - c0, 9);
    wait_idle();

    // Backpressure: req1 7-3=4 held 5 cycles while req0 waits.
    bus.rsp_ready = 1'b0;
    exp_gnt.push_back(1'b1); exp_rsp.push_back('{1'b1, 4'd4});
    set_req(1, 4'd7, 4'd3, 3'd1);
    issue(2'b10);
    set_req(0, 4'd2, 4'd2, 3'd0);
    bus.req0_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) fail("bp_rsp_timeout");
    for (int i = 0; i < 5; i++) begin
      check("bp_no_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
      check("bp_valid_held", bus.rsp_valid, 1'b1);
      tick();
      if (i < 4) @(negedge clk);
    end
    exp_gnt.push_back(1'b0); exp_rsp.push_back('{1'b0, 4'd4});
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("bp_idle_busy", bus.busy, 1'b0);
    check("bp_idle_ready0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    wait_idle();

    // Reset in EXEC: pointer was 0, reset restores priority to req0.
    exp_gnt.push_back(1'b0);
    set_req(0, 4'd1, 4'd2, 3'd0);
    issue(2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_exec_busy", bus.busy, 1'b0);
    check("rst_exec_rsp_valid", bus.rsp_valid, 1'b0);
    tick(); tick(); tick();
    set_req(1, 4'd15, 4'd1, 3'd0);
    exp_gnt.push_back(1'b0); exp_rsp.push_back('{1'b0, 4'd3});
    issue(2'b11);
    wait_idle();

    // Reset in RESP, result held back so it is never taken.
    bus.rsp_ready = 1'b0;
    exp_gnt.push_back(1'b0);
    issue(2'b01);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_resp_busy", bus.busy, 1'b0);
    check("rst_resp_rsp_valid", bus.rsp_valid, 1'b0);
    tick(); tick(); tick();
    exp_gnt.push_back(1'b0); exp_rsp.push_back('{1'b0, 4'd3});
    issue(2'b11);
    wait_idle();

    // Fixed priority: req0 (4>>1=2) wins 3 times, then req1 (8<<1 = 0).
    bus0.req0_a = 4'd4; bus0.req0_b = 4'd1; bus0.req0_op = 3'd3;
    bus0.req1_a = 4'd8; bus0.req1_b = 4'd1; bus0.req1_op = 3'd2;
    for (int i = 0; i < 3; i++) begin
      exp_gnt_fp.push_back(1'b0); exp_rsp_fp.push_back('{1'b0, 4'd2});
    end
    exp_gnt_fp.push_back(1'b1); exp_rsp_fp.push_back('{1'b1, 4'd0});
    bus0.req0_valid = 1'b1; bus0.req1_valid = 1'b1;
    n0 = 0; done1 = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus0.req0_ready) n0++;
      done1 = bus0.req1_ready;
      tick();
      if (n0 == 3) bus0.req0_valid = 1'b0;
      if (done1) break;
    end
    bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
    if (!done1) fail("fp_req1_timeout");
    check("fp_req0_wins", n0, 3);
    repeat (6) tick();

    check("rsp_queue_drained", exp_rsp.size(), 0);
    check("gnt_queue_drained", exp_gnt.size(), 0);
    check("fp_rsp_queue_drained", exp_rsp_fp.size(), 0);
    check("fp_gnt_queue_drained", exp_gnt_fp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 Parameter: RR, default 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 winning.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req0_valid / req1_valid  in  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  out  1  requester n operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  4  operands.
REQ-007 req0_op / req1_op  in  3  opcode: 0 add, 1 sub, 2 shl, 3 shr, 4 and, 5 or, 6 xor, 7 not-a.
REQ-008 ula_a, ula_b  out  4  operands to the shared ALU.
REQ-009 ula_x, ula_y, ula_z  out  1  ALU select, {z,y,x} = opcode.
REQ-010 ula_s  in  4  combinational ALU result.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_id  out  1  requester that owns the result.
REQ-013 rsp_data  out  4  result.
REQ-014 rsp_ready  in  1  consumer takes the result.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP.
REQ-017 IDLE: when any valid is high, the block asserts exactly one ready combinationally, latches operands, opcode and id, and moves to EXEC at the next edge.
REQ-018 Arbitration: with one valid, that requester wins. With both valid and RR=1, the requester not granted last wins. With RR=0, requester 0 wins.
REQ-019 The last-grant pointer updates only on acceptance.
REQ-020 ready is low in EXEC and RESP; valid in those states is ignored and not lost, because requesters hold until ready.
REQ-021 EXEC lasts one cycle: ula_a, ula_b and ula_x/y/z are driven from latched values, ula_s is captured into rsp_data, and the FSM moves to RESP.
REQ-022 RESP: rsp_valid is high and rsp_id/rsp_data are stable until the cycle rsp_ready is high; then the FSM returns to IDLE.
REQ-023 Latency: acceptance in cycle N gives rsp_valid in cycle N+2.
REQ-024 Throughput: at most one operation per 3 cycles with rsp_ready held high.
REQ-025 ula_* outputs hold the latched values in all states, so there are no glitches toward the ALU outside EXEC.
REQ-026 Results are 4-bit with wrap-around (add/sub modulo 16); shl/shr by b>=4 yields 0. These values are as produced by the ALU and are not corrected.
REQ-027 rsp_ready high while not in RESP has no effect.

Reset
REQ-028 When rst is high at an edge: FSM goes to IDLE, last-grant points to requester 1 so requester 0 wins first, and latched operands, opcode, id and rsp_data clear to 0.
REQ-029 During and after reset, ready, rsp_valid and busy are 0 and ula_a/ula_b/x/y/z are 0.
REQ-030 Reset mid-operation (EXEC or RESP) discards the pending result with no rsp_valid pulse; the requester must re-issue.
REQ-031 rst has priority over every other input in the same cycle.

Structure
REQ-032 The shared package holds the opcode constants (OP_ADD..OP_NOT, 3-bit) and the FSM state encoding (2-bit).
REQ-033 One sub-module, ula_rr_arb (2-way arbiter with last-grant pointer and RR parameter), is instantiated once; the ALU is external, not instantiated here.

Verification
REQ-034 Single add: after reset, req0 a=9 b=8 op=0 -> req0_ready at N, rsp_valid at N+2 with id=0, data=1 (wrap).
REQ-035 Contention, RR=1: both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; 4 results in 12 cycles.
REQ-036 Contention, RR=0: both valid -> req0 always granted, req1 starves while req0 valid.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_id stable, no new ready; result taken on the first rsp_ready=1, IDLE next cycle.
REQ-038 All opcodes: a=5 b=2 for op 0..7 -> data 7,3,4,1,0,7,7,10 and ula_{z,y,x} equal op during EXEC.
REQ-039 Reset in EXEC and in RESP -> no rsp_valid, busy=0 next cycle, next grant goes to req0.
